eif_stim_sequencer: RTL

Programmable stimulus controller for the EIF neuron datapath. It plays out an 8-entry table of input-current values, each held for a configurable number of clock cycles, on the neuron's 8-bit current input. It counts the neuron's output spikes while a run is active. It sits between the top-level pins and eif_neuron and replaces the direct ui_in-to-current connection when sequenced stimulus is wanted.

---
 rtl/eif_stim_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/eif_stim_sequencer.sv
// eif_stim_sequencer
// Plays an 8-entry table of input-current values onto the EIF neuron's current
// input. Each entry is held for a programmable number of cycles. The block also
// counts rising edges of the neuron's spike output while a run is active.
// All outputs are registered, so they change only on clock edges or on reset.

module eif_stim_sequencer #(
    parameter int DEPTH = 8,
    parameter int CUR_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_addr,
    input  logic [7:0]                 cfg_data,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       spike_in,
    output logic [CUR_W-1:0]           current_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic [CNT_W-1:0]           spike_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg, state_next;

    // Configuration storage
    logic [CUR_W-1:0]   table_reg [DEPTH];
    logic [7:0]         dur_reg;
    logic [AW-1:0]      nsteps_reg;
    logic               loop_reg;

    // Run-time state
    logic [7:0]         dwell_reg, dwell_next;
    logic [AW-1:0]      step_reg, step_next;
    logic [CUR_W-1:0]   cur_reg, cur_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               prev_reg;

    logic               cfg_ok;
    logic [DEPTH-1:0]   entry_we;
    logic [7:0]         dur_eff;
    logic [AW-1:0]      step_inc;
    logic               spike_rise;

    // Configuration is only accepted while idle, so a run never sees its table change.
    assign cfg_ok     = cfg_we && (state_reg == IDLE);
    // A programmed duration of 0 behaves like 1 so every step lasts at least one cycle.
    assign dur_eff    = (dur_reg == 8'd0) ? 8'd1 : dur_reg;
    assign step_inc   = step_reg + AW'(1);
    assign spike_rise = spike_in && !prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = cfg_ok && (cfg_addr == 4'(gi));
        end
    endgenerate

    // Current table: one write-enabled register per entry, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    table_reg[i] <= CUR_W'(cfg_data);
                end
            end
        end
    end

    // Scalar configuration registers: step duration, last step index, loop mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_reg    <= 8'd1;
            nsteps_reg <= '0;
            loop_reg   <= 1'b0;
        end else if (cfg_ok) begin
            case (cfg_addr)
                4'd8:    dur_reg    <= cfg_data;
                4'd9:    nsteps_reg <= cfg_data[AW-1:0];
                4'd10:   loop_reg   <= cfg_data[0];
                default: ;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            dwell_reg <= '0;
            step_reg  <= '0;
            cur_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
            prev_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            dwell_reg <= dwell_next;
            step_reg  <= step_next;
            cur_reg   <= cur_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            cnt_reg   <= cnt_next;
            prev_reg  <= spike_in;
        end
    end

    // Next-state logic: start/stop handling, dwell countdown, step advance and spike counting.
    always_comb begin
        state_next = state_reg;
        dwell_next = dwell_reg;
        step_next  = step_reg;
        cur_next   = cur_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        cnt_next   = cnt_reg;

        // Count rising spike edges seen in a busy cycle; saturate at all-ones.
        if (busy_reg && spike_rise && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    state_next = RUN;
                    step_next  = '0;
                    cur_next   = table_reg[0];
                    busy_next  = 1'b1;
                    dwell_next = dur_eff;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    // Abort: return to idle without signalling completion.
                    state_next = IDLE;
                    step_next  = '0;
                    cur_next   = '0;
                    busy_next  = 1'b0;
                end else if (dwell_reg == 8'd1) begin
                    if (step_reg < nsteps_reg) begin
                        step_next  = step_inc;
                        cur_next   = table_reg[step_inc];
                        dwell_next = dur_eff;
                    end else if (loop_reg) begin
                        step_next  = '0;
                        cur_next   = table_reg[0];
                        dwell_next = dur_eff;
                    end else begin
                        state_next = IDLE;
                        step_next  = '0;
                        cur_next   = '0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end else begin
                    dwell_next = dwell_reg - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign current_out = cur_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign step_idx    = step_reg;
    assign spike_count = cnt_reg;

endmodule
